// File: rtl/vcap_pkg.sv
// ---------------------------------------------------------------------------
// vcap_pkg : shared types and sizing helpers for video_capture_ctrl
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vcap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } vcap_state_e;

   localparam int RGB_W = 24;
   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   function automatic int vcap_total(input int hdisp, input int vdisp);
      return hdisp * vdisp;
   endfunction

   // Width of a counter that must be able to hold the value max_val itself.
   function automatic int vcap_cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/vcap_edge_det.sv
// ---------------------------------------------------------------------------
// vcap_edge_det : registers one input and flags its rising/falling edges
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vcap_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic sig_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = ~sig_q & sig_i;
   assign fall_o = sig_q & ~sig_i;

endmodule

`default_nettype wire

// File: rtl/video_capture_ctrl.sv
// ---------------------------------------------------------------------------
// video_capture_ctrl : skips START_FRAME frame boundaries, then writes one
//                      frame of 24-bit video into a linear frame-buffer port.
//                      Define VCAP_LINE_CHK_EN for per-line geometry checking.
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module video_capture_ctrl
   import vcap_pkg::*;
#(
   parameter int IMG_HDISP   = 640,
   parameter int IMG_VDISP   = 480,
   parameter int START_FRAME = 1,
   parameter int ADDR_W      = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_start,
   output logic              cap_busy,
   output logic              cap_done,
   output logic              cap_err,
   input  logic              video_vsync,
   input  logic              video_hsync,
   input  logic              video_de,
   input  logic [RGB_W-1:0]  video_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [RGB_W-1:0]  mem_wdata
);

   localparam int TOTAL  = vcap_total(IMG_HDISP, IMG_VDISP);
   localparam int PIX_W  = vcap_cnt_w(TOTAL);
   localparam int SKIP_W = vcap_cnt_w(START_FRAME);

   vcap_state_e       state_q, state_d;
   logic [SKIP_W-1:0] skip_q, skip_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [RGB_W-1:0]  wdata_q, wdata_d;

   logic fe;
   logic accept;
   logic pix_vld;
   logic line_err;
   logic unused_vs_rise;
   logic unused_hsync;

   assign unused_hsync = video_hsync;

   vcap_edge_det u_vs_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (video_vsync),
      .rise_o (unused_vs_rise),
      .fall_o (fe)
   );

   assign accept  = (state_q == IDLE) && cap_start;
   assign pix_vld = (state_q == CAPTURE) && video_de && !fe;

`ifdef VCAP_LINE_CHK_EN
   localparam int LEN_W   = vcap_cnt_w(IMG_HDISP);
   localparam int LINES_W = vcap_cnt_w(IMG_VDISP);

   logic [LEN_W-1:0]   len_q;
   logic [LINES_W-1:0] lines_q;
   logic               de_fall;
   logic               unused_de_rise;

   vcap_edge_det u_de_edge (
      .clk    (clk),
      .rst    (rst),
      .sig_i  (video_de),
      .rise_o (unused_de_rise),
      .fall_o (de_fall)
   );

   // Overflow pixels still count toward line length so long lines are caught.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q   <= '0;
         lines_q <= '0;
      end else if (accept) begin
         len_q   <= '0;
         lines_q <= '0;
      end else if (state_q == CAPTURE) begin
         if (de_fall) begin
            len_q <= '0;
            if (lines_q != '1) lines_q <= lines_q + 1'b1;
         end else if (pix_vld && len_q != '1) begin
            len_q <= len_q + 1'b1;
         end
      end
   end

   assign line_err = (state_q == CAPTURE) &&
                     ((de_fall && len_q != LEN_W'(IMG_HDISP)) ||
                      (fe && lines_q != LINES_W'(IMG_VDISP)));
`else
   assign line_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      pix_d   = pix_q;
      err_d   = err_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (cap_start) begin
               state_d = ARM;
               skip_d  = '0;
               pix_d   = '0;
               err_d   = 1'b0;
            end
         end
         ARM: begin
            if (fe) begin
               skip_d = skip_q + 1'b1;
               if (int'(skip_q) + 1 == START_FRAME) state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (fe) begin
               state_d = DONE;
               if (pix_q != PIX_W'(TOTAL)) err_d = 1'b1;
            end else if (video_de) begin
               if (pix_q < PIX_W'(TOTAL)) begin
                  we_d    = 1'b1;
                  addr_d  = ADDR_W'(pix_q);
                  wdata_d = {video_data[R_LSB +: 8], video_data[G_LSB +: 8],
                             video_data[B_LSB +: 8]};
                  pix_d   = pix_q + 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (line_err) err_d = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         skip_q  <= '0;
         pix_q   <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         pix_q   <= pix_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign cap_busy  = (state_q != IDLE);
   assign cap_done  = (state_q == DONE);
   assign cap_err   = err_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

`default_nettype wire
